// File: rtl/nand4_stim_checker.sv
// On-board exerciser for the 4-input NAND lab block: walks all 16 input
// vectors, samples the three NAND outputs and reports pass/fail and error details.
module nand4_stim_checker #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned ERR_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ina,
    output logic             inb,
    output logic             inc,
    output logic             ind,
    input  logic             oute,
    input  logic             outf,
    input  logic             outg,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [3:0]       first_err_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_e;

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_e           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             fev_valid_q, fev_valid_d;
    logic [3:0]       fev_q, fev_d;

    logic [2:0]       expected;
    logic             mismatch;

    assign expected = {~(vec_q[3] & vec_q[2]), ~(vec_q[1] & vec_q[0]), ~(&vec_q)};
    assign mismatch = ({oute, outf, outg} != expected);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        fev_valid_d = fev_valid_q;
        fev_d       = fev_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_SETTLE;
                    vec_d       = '0;
                    cnt_d       = SETTLE_LOAD;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    fev_valid_d = 1'b0;
                    fev_d       = '0;
                end else if (state_q == S_DONE) begin
                    // Published one cycle after entry so pass sees the final error count.
                    done_d = 1'b1;
                    pass_d = (err_cnt_q == '0);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!fev_valid_q) begin
                        fev_valid_d = 1'b1;
                        fev_d       = vec_q;
                    end
                end
                if (vec_q == 4'hF) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETTLE;
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            fev_valid_q <= 1'b0;
            fev_q       <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            fev_valid_q <= fev_valid_d;
            fev_q       <= fev_d;
        end
    end

    assign ina             = vec_q[3];
    assign inb             = vec_q[2];
    assign inc             = vec_q[1];
    assign ind             = vec_q[0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fev_valid_q;
    assign first_err_vec   = fev_q;

endmodule

// File: tb/tb_nand4_stim_checker.sv
// Self-checking bench: three checker instances (SETTLE/ERR_W variants) driven by
// selectable NAND response models, compared against an arithmetic reference.
module tb_nand4_stim_checker;

    localparam int N = 3;
    localparam int SC_P [N] = '{4, 4, 1};
    localparam int EW_P [N] = '{5, 3, 5};

    // Response modes of the emulated lab block
    localparam int M_GOLD   = 0;
    localparam int M_G_SA1  = 1;
    localparam int M_E_INV  = 2;
    localparam int M_RANDOM = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] start;
    int           mode [N];
    logic [2:0]   rand_tbl [16];

    logic [3:0]   vec_o  [N];
    logic         busy_o [N];
    logic         done_o [N];
    logic         pass_o [N];
    logic [4:0]   err_o  [N];
    logic         fevv_o [N];
    logic [3:0]   fev_o  [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] golden(input logic [3:0] v);
        logic e, f, g;
        e = ((v >> 2) == 4'd3) ? 1'b0 : 1'b1;
        f = ((v & 4'd3) == 4'd3) ? 1'b0 : 1'b1;
        g = (v == 4'd15) ? 1'b0 : 1'b1;
        return {e, f, g};
    endfunction

    function automatic logic [2:0] resp_f(input int m, input logic [3:0] v, input logic [2:0] flip);
        logic [2:0] r;
        r = golden(v);
        case (m)
            M_G_SA1:  r[0] = 1'b1;
            M_E_INV:  r[2] = ~r[2];
            M_RANDOM: r = r ^ flip;
            default:  ;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [EW_P[g]-1:0] err;
        logic               a, b, c, d, bsy, dn, ps, fvv;
        logic [3:0]         fv;
        logic [2:0]         rsp;

        always_comb rsp = resp_f(mode[g], {a, b, c, d}, rand_tbl[{a, b, c, d}]);

        nand4_stim_checker #(.SETTLE_CYC(SC_P[g]), .ERR_W(EW_P[g])) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .start           (start[g]),
            .ina             (a),
            .inb             (b),
            .inc             (c),
            .ind             (d),
            .oute            (rsp[2]),
            .outf            (rsp[1]),
            .outg            (rsp[0]),
            .busy            (bsy),
            .done            (dn),
            .pass            (ps),
            .err_cnt         (err),
            .first_err_valid (fvv),
            .first_err_vec   (fv)
        );

        assign vec_o[g]  = {a, b, c, d};
        assign busy_o[g] = bsy;
        assign done_o[g] = dn;
        assign pass_o[g] = ps;
        assign err_o[g]  = 5'(err);
        assign fevv_o[g] = fvv;
        assign fev_o[g]  = fv;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One full run on instance k; poke >= 0 re-pulses start at that observation.
    task automatic run(input int k, input int poke, input string tag);
        int  per, last, exp_done, n, n_done, fails, first, sat;
        bit  vec_bad, busy_bad, finished;
        per      = SC_P[k] + 1;
        last     = 16 * per;
        exp_done = last + 1;
        sat      = (1 << EW_P[k]) - 1;
        fails    = 0;
        first    = -1;
        for (int v = 0; v < 16; v++) begin
            if (resp_f(mode[k], 4'(v), rand_tbl[v]) != golden(4'(v))) begin
                fails++;
                if (first < 0) first = v;
            end
        end

        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;

        n        = 0;
        n_done   = -1;
        vec_bad  = 1'b0;
        busy_bad = 1'b0;
        finished = 1'b0;
        while (!finished && n <= exp_done + 20) begin
            @(negedge clk);
            if (n == 0) begin
                check({tag, "_start_done_clr"}, int'(done_o[k]), 0);
                check({tag, "_start_err_clr"}, int'(err_o[k]), 0);
                check({tag, "_start_fevv_clr"}, int'(fevv_o[k]), 0);
            end
            start[k] = (n == poke);
            if (int'(vec_o[k]) != ((n < last) ? n / per : 15)) vec_bad = 1'b1;
            if (busy_o[k] != (n < last)) busy_bad = 1'b1;
            if (done_o[k]) begin
                n_done   = n;
                finished = 1'b1;
            end
            n++;
        end
        start[k] = 1'b0;

        check({tag, "_done_edge"}, n_done, exp_done);
        check({tag, "_vec_seq"}, int'(vec_bad), 0);
        check({tag, "_busy"}, int'(busy_bad), 0);
        check({tag, "_pass"}, int'(pass_o[k]), (fails == 0) ? 1 : 0);
        check({tag, "_err_cnt"}, int'(err_o[k]), (fails > sat) ? sat : fails);
        check({tag, "_fev_valid"}, int'(fevv_o[k]), (fails > 0) ? 1 : 0);
        check({tag, "_fev"}, int'(fev_o[k]), (first < 0) ? 0 : first);
    endtask

    // Start a failing run on instance 0 and pull reset mid-SETTLE of vector 9.
    task automatic abort_run();
        mode[0] = M_E_INV;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        for (int n = 0; n < 46; n++) @(negedge clk);
        check("abort_vec_before", int'(vec_o[0]), 9);
        check("abort_err_before", int'(err_o[0]), 9);
        #2 rst_n = 1'b0;
        #1;
        check("abort_vec_rst", int'(vec_o[0]), 0);
        check("abort_busy_rst", int'(busy_o[0]), 0);
        check("abort_err_rst", int'(err_o[0]), 0);
        check("abort_done_rst", int'(done_o[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_idle_busy", int'(busy_o[0]), 0);
        check("abort_idle_done", int'(done_o[0]), 0);
        check("abort_idle_vec", int'(vec_o[0]), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = '0;
        for (int i = 0; i < N; i++) mode[i] = M_GOLD;
        for (int v = 0; v < 16; v++) rand_tbl[v] = '0;
        #17;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_vec%0d", i), int'(vec_o[i]), 0);
            check($sformatf("rst_busy%0d", i), int'(busy_o[i]), 0);
            check($sformatf("rst_done%0d", i), int'(done_o[i]), 0);
            check($sformatf("rst_pass%0d", i), int'(pass_o[i]), 0);
            check($sformatf("rst_err%0d", i), int'(err_o[i]), 0);
            check($sformatf("rst_fev%0d", i), int'({fevv_o[i], fev_o[i]}), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", int'(busy_o[0]), 0);

        mode[0] = M_GOLD;   run(0, -1, "gold");
        mode[0] = M_G_SA1;  run(0, -1, "g_sa1");
        mode[0] = M_E_INV;  run(0, -1, "e_inv");
        mode[1] = M_E_INV;  run(1, -1, "e_inv_sat");

        // Restart attempt during vector 6, then a fresh start straight from DONE
        mode[0] = M_G_SA1;  run(0, 6 * 5 + 2, "busy_start");
        mode[0] = M_GOLD;   run(0, -1, "restart");

        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < 16; v++)
                rand_tbl[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            mode[r % 2] = M_RANDOM;
            run(r % 2, -1, $sformatf("rand%0d", r));
        end

        abort_run();
        mode[0] = M_GOLD;   run(0, -1, "post_abort");

        mode[2] = M_GOLD;   run(2, -1, "settle1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
